// File: rtl/lap_timer_pkg.sv
// Shared definitions for the lap timer: FSM state encoding and seconds limit.
package lap_timer_pkg;

  // State encoding doubles as the externally visible status code.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10,
    EXPIRED = 2'b11
  } state_t;

  localparam int SEC_MAX = 59;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock down to one count step every TICK_DIV cycles while running.
module tick_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = run && (count == LAST);

  // Phase counter: cleared on request, advances only while running, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/lap_timer.sv
// Stopwatch / countdown timer with pause, preload and lap capture.
module lap_timer
  import lap_timer_pkg::*;
#(
  parameter int TICK_DIV = 1,
  parameter int MIN_W    = 6,
  parameter int MIN_MAX  = 59
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             reset,
  input  logic             lap,
  input  logic             mode,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [5:0]       load_sec,
  output logic [MIN_W-1:0] minutes,
  output logic [5:0]       seconds,
  output logic [MIN_W-1:0] lap_min,
  output logic [5:0]       lap_sec,
  output logic             lap_valid,
  output logic [1:0]       status,
  output logic             done
);

  state_t           state, next_state;
  logic             mode_q;
  logic             tick, run, clear;
  logic [MIN_W-1:0] load_min_sat;
  logic [5:0]       load_sec_sat;
  logic             eff_zero, start_ok, expire;

  assign load_min_sat = (load_min > MIN_W'(MIN_MAX)) ? MIN_W'(MIN_MAX) : load_min;
  assign load_sec_sat = (load_sec > 6'(SEC_MAX)) ? 6'(SEC_MAX) : load_sec;

  // The zero-count start guard looks at the count as it will be after a same-cycle
  // load, and at the direction that is being latched for the run.
  assign eff_zero = load ? (load_min_sat == '0 && load_sec_sat == '0)
                         : (minutes == '0 && seconds == '0);
  assign start_ok = !(mode && eff_zero);

  // A stop in the same cycle as a tick swallows the tick and freezes the prescaler.
  assign run    = (state == RUNNING) && !stop && !reset;
  assign clear  = reset || (state == IDLE) || (state == EXPIRED);
  assign expire = tick && mode_q && (minutes == '0) && (seconds == 6'd1);
  assign status = state;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .clear (clear),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic with reset > stop > start priority.
  always_comb begin
    next_state = state;
    if (reset) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (!stop && start && start_ok) next_state = RUNNING;
        RUNNING: if (stop) next_state = PAUSED;
                 else if (expire) next_state = EXPIRED;
        PAUSED:  if (!stop && start) next_state = RUNNING;
        EXPIRED: next_state = EXPIRED;
        default: next_state = IDLE;
      endcase
    end
  end

  // Direction is tracked while idle and frozen for the rest of the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             mode_q <= 1'b0;
    else if (state == IDLE) mode_q <= mode;
  end

  // Live count: clear, preload while idle, or step up/down on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      minutes <= '0;
      seconds <= '0;
    end else if (reset) begin
      minutes <= '0;
      seconds <= '0;
    end else if (state == IDLE && load) begin
      minutes <= load_min_sat;
      seconds <= load_sec_sat;
    end else if (tick) begin
      if (mode_q) begin
        if (seconds == '0) begin
          seconds <= 6'(SEC_MAX);
          minutes <= minutes - 1'b1;
        end else begin
          seconds <= seconds - 1'b1;
        end
      end else begin
        if (seconds == 6'(SEC_MAX)) begin
          seconds <= '0;
          minutes <= (minutes == MIN_W'(MIN_MAX)) ? '0 : minutes + 1'b1;
        end else begin
          seconds <= seconds + 1'b1;
        end
      end
    end
  end

  // Lap capture of the pre-tick count while running, with a one-cycle valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_min   <= '0;
      lap_sec   <= '0;
      lap_valid <= 1'b0;
    end else begin
      lap_valid <= 1'b0;
      if (reset) begin
        lap_min <= '0;
        lap_sec <= '0;
      end else if (state == RUNNING && lap) begin
        lap_min   <= minutes;
        lap_sec   <= seconds;
        lap_valid <= 1'b1;
      end
    end
  end

  // Countdown completion pulse, raised on the same edge that enters EXPIRED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= expire;
  end

endmodule

// File: tb/tb_lap_timer.sv
// Self-checking bench: two timer instances (default, and TICK_DIV=4/MIN_MAX=2)
// share stimulus; directed scenarios plus a randomized run against a reference model.
module tb_lap_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, reset, lap, mode, load;
  logic [5:0] load_min, load_sec;

  logic [5:0] a_min, a_sec, a_lmin, a_lsec, b_min, b_sec, b_lmin, b_lsec;
  logic [1:0] a_st, b_st;
  logic       a_lv, a_done, b_lv, b_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lap_timer dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .reset(reset), .lap(lap),
    .mode(mode), .load(load), .load_min(load_min), .load_sec(load_sec),
    .minutes(a_min), .seconds(a_sec), .lap_min(a_lmin), .lap_sec(a_lsec),
    .lap_valid(a_lv), .status(a_st), .done(a_done)
  );

  lap_timer #(.TICK_DIV(4), .MIN_W(6), .MIN_MAX(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .reset(reset), .lap(lap),
    .mode(mode), .load(load), .load_min(load_min), .load_sec(load_sec),
    .minutes(b_min), .seconds(b_sec), .lap_min(b_lmin), .lap_sec(b_lsec),
    .lap_valid(b_lv), .status(b_st), .done(b_done)
  );

  // Reference model: the count is a single number of seconds, status uses the
  // published codes 0 idle, 1 running, 2 paused, 3 expired.
  typedef struct {
    int st;
    int total;
    int pre;
    int md;
    int lap_total;
    int lv;
    int dn;
  } model_t;

  model_t ma, mb;

  function automatic model_t step(model_t m, logic s, logic p, logic r, logic l, logic md,
                                  logic ld, int lmin, int lsec, int tdiv, int mmax);
    model_t n = m;
    int span = (mmax + 1) * 60;
    int eff;
    n.lv = 0;
    n.dn = 0;
    if (m.st == 0) n.md = int'(md);
    if (r) begin
      n.st = 0; n.total = 0; n.pre = 0; n.lap_total = 0;
      return n;
    end
    case (m.st)
      0: begin
        n.pre = 0;
        eff = m.total;
        if (ld) eff = ((lmin > mmax) ? mmax : lmin) * 60 + ((lsec > 59) ? 59 : lsec);
        n.total = eff;
        if (s && !p && !(md && eff == 0)) n.st = 1;
      end
      1: begin
        if (l) begin n.lap_total = m.total; n.lv = 1; end
        if (p) n.st = 2;
        else if (m.pre == tdiv - 1) begin
          n.pre = 0;
          if (m.md != 0) begin
            n.total = m.total - 1;
            if (n.total == 0) begin n.st = 3; n.dn = 1; end
          end else begin
            n.total = (m.total + 1) % span;
          end
        end else n.pre = m.pre + 1;
      end
      2: if (s && !p) n.st = 1;
      default: n.pre = 0;
    endcase
    return n;
  endfunction

  task automatic clock_cycle();
    ma = step(ma, start, stop, reset, lap, mode, load, int'(load_min), int'(load_sec), 1, 59);
    mb = step(mb, start, stop, reset, lap, mode, load, int'(load_min), int'(load_sec), 4, 2);
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    {start, stop, reset, lap, mode, load} = '0;
    load_min = '0;
    load_sec = '0;
    rst_n = 1'b0;
    #3;
    ma = '{default: 0};
    mb = '{default: 0};
    @(negedge clk);
    rst_n = 1'b1;
    clock_cycle();
  endtask

  task automatic test_reset();
    {start, stop, reset, lap, mode, load} = '0;
    load_min = '0;
    load_sec = '0;
    rst_n = 1'b0;
    #2;
    tests++;
    if ({a_st, a_min, a_sec, a_lmin, a_lsec, a_lv, a_done} !== 28'h0) begin
      $display("[TB] FAIL reset_a: got %h expected 0", {a_st, a_min, a_sec, a_lmin, a_lsec, a_lv, a_done});
      fails++;
    end
    tests++;
    if ({b_st, b_min, b_sec, b_lmin, b_lsec, b_lv, b_done} !== 28'h0) begin
      $display("[TB] FAIL reset_b: got %h expected 0", {b_st, b_min, b_sec, b_lmin, b_lsec, b_lv, b_done});
      fails++;
    end
    do_rst();
    tests++;
    if ({a_st, a_min, a_sec} !== 14'h0) begin
      $display("[TB] FAIL reset_release: got %h expected 0", {a_st, a_min, a_sec});
      fails++;
    end
  endtask

  task automatic test_count_up();
    do_rst();
    start = 1'b1;
    clock_cycle();
    start = 1'b0;
    tests++;
    if ({a_st, a_min, a_sec} !== {2'd1, 6'd0, 6'd0}) begin
      $display("[TB] FAIL start_latency: got %h expected %h", {a_st, a_min, a_sec}, {2'd1, 6'd0, 6'd0});
      fails++;
    end
    repeat (61) clock_cycle();
    tests++;
    if ({a_st, a_min, a_sec} !== {2'd1, 6'd1, 6'd1}) begin
      $display("[TB] FAIL count_up_61: got %h expected %h", {a_st, a_min, a_sec}, {2'd1, 6'd1, 6'd1});
      fails++;
    end
    tests++;
    if ({b_min, b_sec} !== {6'd0, 6'd15}) begin
      $display("[TB] FAIL count_up_div4: got %h expected %h", {b_min, b_sec}, {6'd0, 6'd15});
      fails++;
    end
  endtask

  task automatic test_pause();
    do_rst();
    start = 1'b1;
    clock_cycle();
    start = 1'b0;
    repeat (8) clock_cycle();
    tests++;
    if (b_sec !== 6'd2) begin
      $display("[TB] FAIL pause_pre: got %0d expected 2", b_sec);
      fails++;
    end
    stop = 1'b1;
    clock_cycle();
    stop = 1'b0;
    repeat (20) clock_cycle();
    tests++;
    if ({b_st, b_sec} !== {2'd2, 6'd2}) begin
      $display("[TB] FAIL pause_hold: got %h expected %h", {b_st, b_sec}, {2'd2, 6'd2});
      fails++;
    end
    start = 1'b1;
    clock_cycle();
    start = 1'b0;
    repeat (3) clock_cycle();
    tests++;
    if ({b_st, b_sec} !== {2'd1, 6'd2}) begin
      $display("[TB] FAIL resume_early: got %h expected %h", {b_st, b_sec}, {2'd1, 6'd2});
      fails++;
    end
    clock_cycle();
    tests++;
    if (b_sec !== 6'd3) begin
      $display("[TB] FAIL resume_final: got %0d expected 3", b_sec);
      fails++;
    end
  endtask

  task automatic test_stop_tick();
    do_rst();
    start = 1'b1;
    clock_cycle();
    start = 1'b0;
    repeat (3) clock_cycle();
    stop = 1'b1;
    clock_cycle();
    stop = 1'b0;
    tests++;
    if ({b_st, b_sec} !== {2'd2, 6'd0}) begin
      $display("[TB] FAIL stop_on_tick: got %h expected %h", {b_st, b_sec}, {2'd2, 6'd0});
      fails++;
    end
    tests++;
    if ({a_st, a_sec} !== {2'd2, 6'd3}) begin
      $display("[TB] FAIL stop_on_tick_div1: got %h expected %h", {a_st, a_sec}, {2'd2, 6'd3});
      fails++;
    end
    start = 1'b1;
    clock_cycle();
    start = 1'b0;
    clock_cycle();
    tests++;
    if (b_sec !== 6'd1) begin
      $display("[TB] FAIL prescaler_held: got %0d expected 1", b_sec);
      fails++;
    end
  endtask

  task automatic test_countdown();
    do_rst();
    mode = 1'b1;
    load = 1'b1;
    load_sec = 6'd3;
    clock_cycle();
    load = 1'b0;
    start = 1'b1;
    clock_cycle();
    start = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      clock_cycle();
      tests++;
      if (a_sec !== 6'(i)) begin
        $display("[TB] FAIL countdown_step: got %0d expected %0d", a_sec, i);
        fails++;
      end
    end
    tests++;
    if ({a_st, a_min, a_done} !== {2'd3, 6'd0, 1'b1}) begin
      $display("[TB] FAIL expire: got %h expected %h", {a_st, a_min, a_done}, {2'd3, 6'd0, 1'b1});
      fails++;
    end
    clock_cycle();
    tests++;
    if ({a_st, a_done} !== {2'd3, 1'b0}) begin
      $display("[TB] FAIL done_pulse: got %h expected %h", {a_st, a_done}, {2'd3, 1'b0});
      fails++;
    end
    {start, lap, load} = 3'b111;
    load_sec = 6'd20;
    clock_cycle();
    {start, lap, load} = 3'b000;
    tests++;
    if ({a_st, a_sec, a_lv} !== {2'd3, 6'd0, 1'b0}) begin
      $display("[TB] FAIL expired_ignore: got %h expected %h", {a_st, a_sec, a_lv}, {2'd3, 6'd0, 1'b0});
      fails++;
    end
    do_rst();
    mode = 1'b1;
    clock_cycle();
    start = 1'b1;
    clock_cycle();
    start = 1'b0;
    tests++;
    if (a_st !== 2'd0) begin
      $display("[TB] FAIL zero_start_ignored: got %0d expected 0", a_st);
      fails++;
    end
  endtask

  task automatic test_wrap();
    do_rst();
    load = 1'b1;
    load_min = 6'd63;
    load_sec = 6'd63;
    clock_cycle();
    load = 1'b0;
    tests++;
    if ({a_min, a_sec, b_min, b_sec} !== {6'd59, 6'd59, 6'd2, 6'd59}) begin
      $display("[TB] FAIL load_saturate: got %h expected %h", {a_min, a_sec, b_min, b_sec}, {6'd59, 6'd59, 6'd2, 6'd59});
      fails++;
    end
    start = 1'b1;
    clock_cycle();
    start = 1'b0;
    clock_cycle();
    tests++;
    if ({a_st, a_min, a_sec} !== {2'd1, 6'd0, 6'd0}) begin
      $display("[TB] FAIL wrap_59: got %h expected %h", {a_st, a_min, a_sec}, {2'd1, 6'd0, 6'd0});
      fails++;
    end
    repeat (2) clock_cycle();
    clock_cycle();
    tests++;
    if ({b_st, b_min, b_sec} !== {2'd1, 6'd0, 6'd0}) begin
      $display("[TB] FAIL wrap_minmax2: got %h expected %h", {b_st, b_min, b_sec}, {2'd1, 6'd0, 6'd0});
      fails++;
    end
  endtask

  task automatic test_lap();
    do_rst();
    start = 1'b1;
    clock_cycle();
    start = 1'b0;
    repeat (7) clock_cycle();
    lap = 1'b1;
    clock_cycle();
    lap = 1'b0;
    tests++;
    if ({a_sec, a_lmin, a_lsec, a_lv} !== {6'd8, 6'd0, 6'd7, 1'b1}) begin
      $display("[TB] FAIL lap_capture: got %h expected %h", {a_sec, a_lmin, a_lsec, a_lv}, {6'd8, 6'd0, 6'd7, 1'b1});
      fails++;
    end
    clock_cycle();
    tests++;
    if ({a_lsec, a_lv} !== {6'd7, 1'b0}) begin
      $display("[TB] FAIL lap_pulse: got %h expected %h", {a_lsec, a_lv}, {6'd7, 1'b0});
      fails++;
    end
    stop = 1'b1;
    clock_cycle();
    stop = 1'b0;
    lap = 1'b1;
    clock_cycle();
    lap = 1'b0;
    tests++;
    if ({a_lsec, a_lv} !== {6'd7, 1'b0}) begin
      $display("[TB] FAIL lap_paused: got %h expected %h", {a_lsec, a_lv}, {6'd7, 1'b0});
      fails++;
    end
  endtask

  task automatic test_priority();
    do_rst();
    start = 1'b1;
    clock_cycle();
    start = 1'b0;
    repeat (4) clock_cycle();
    lap = 1'b1;
    clock_cycle();
    lap = 1'b0;
    {reset, stop, start} = 3'b111;
    clock_cycle();
    {reset, stop, start} = 3'b000;
    tests++;
    if ({a_st, a_min, a_sec, a_lsec} !== 20'h0) begin
      $display("[TB] FAIL reset_priority: got %h expected 0", {a_st, a_min, a_sec, a_lsec});
      fails++;
    end
    start = 1'b1;
    clock_cycle();
    start = 1'b0;
    repeat (3) clock_cycle();
    lap = 1'b1;
    clock_cycle();
    lap = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({a_st, a_min, a_sec, a_lmin, a_lsec, a_lv, a_done} !== 28'h0) begin
      $display("[TB] FAIL async_reset: got %h expected 0", {a_st, a_min, a_sec, a_lmin, a_lsec, a_lv, a_done});
      fails++;
    end
    do_rst();
  endtask

  task automatic test_random();
    logic [27:0] exp_a, exp_b;
    do_rst();
    for (int i = 0; i < 800; i++) begin
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 11) == 0);
      reset = ($urandom_range(0, 39) == 0);
      lap   = ($urandom_range(0, 5) == 0);
      load  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      load_min = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 2));
      load_sec = 6'($urandom_range(0, 63));
      clock_cycle();
      exp_a = {2'(ma.st), 6'(ma.total / 60), 6'(ma.total % 60),
               6'(ma.lap_total / 60), 6'(ma.lap_total % 60), 1'(ma.lv), 1'(ma.dn)};
      exp_b = {2'(mb.st), 6'(mb.total / 60), 6'(mb.total % 60),
               6'(mb.lap_total / 60), 6'(mb.lap_total % 60), 1'(mb.lv), 1'(mb.dn)};
      tests++;
      if ({a_st, a_min, a_sec, a_lmin, a_lsec, a_lv, a_done} !== exp_a) begin
        $display("[TB] FAIL random_a cycle %0d: got %h expected %h", i,
                 {a_st, a_min, a_sec, a_lmin, a_lsec, a_lv, a_done}, exp_a);
        fails++;
      end
      tests++;
      if ({b_st, b_min, b_sec, b_lmin, b_lsec, b_lv, b_done} !== exp_b) begin
        $display("[TB] FAIL random_b cycle %0d: got %h expected %h", i,
                 {b_st, b_min, b_sec, b_lmin, b_lsec, b_lv, b_done}, exp_b);
        fails++;
      end
    end
    {start, stop, reset, lap, load} = '0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_pause();
    test_stop_tick();
    test_countdown();
    test_wrap();
    test_lap();
    test_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lap_timer.md
LAP_TIMER -- requirements
Module: lap_timer

Interface
REQ-001 Parameter TICK_DIV, default 1, clock cycles per one-second count step; legal range >=1.
REQ-002 Parameter MIN_W, default 6, width of minutes fields.
REQ-003 Parameter MIN_MAX, default 59, highest minutes value; legal range 1..2^MIN_W-1.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port start  input  1  single-cycle start/resume request.
REQ-007 Port stop  input  1  single-cycle pause request.
REQ-008 Port reset  input  1  synchronous clear-to-idle request.
REQ-009 Port lap  input  1  single-cycle lap capture request.
REQ-010 Port mode  input  1  0 = count up, 1 = count down; sampled only in IDLE.
REQ-011 Port load  input  1  preload strobe, honoured only in IDLE.
REQ-012 Port load_min / load_sec  input  MIN_W / 6  preload value.
REQ-013 Port minutes / seconds  output  MIN_W / 6  live count.
REQ-014 Port lap_min / lap_sec  output  MIN_W / 6  last captured lap value.
REQ-015 Port lap_valid  output  1  one-cycle pulse, lap registers updated.
REQ-016 Port status  output  2  00 IDLE, 01 RUNNING, 10 PAUSED, 11 EXPIRED.
REQ-017 Port done  output  1  one-cycle pulse on countdown reaching 00:00.

Function
REQ-018 FSM states IDLE, RUNNING, PAUSED, EXPIRED; status equals state encoding, registered.
REQ-019 Request priority per cycle: reset > stop > start; lower-priority requests that cycle are dropped.
REQ-020 IDLE+start -> RUNNING; RUNNING+stop -> PAUSED; PAUSED+start -> RUNNING; any state+reset -> IDLE with count, prescaler, lap regs cleared to 0.
REQ-021 start in IDLE with latched mode=1 and count 00:00 is ignored (stays IDLE).
REQ-022 Latched mode register updated from mode every cycle in IDLE, held in all other states.
REQ-023 load in IDLE writes count from load_min/load_sec, each field saturated to MIN_MAX/59; load outside IDLE ignored; start and load same cycle: load applies, then transition to RUNNING.
REQ-024 Prescaler counts 0..TICK_DIV-1 only in RUNNING, held in PAUSED, cleared in IDLE/EXPIRED; tick asserted when prescaler = TICK_DIV-1 and state RUNNING.
REQ-025 Latency: with TICK_DIV=1, start sampled at edge N -> status 01 after edge N, seconds changes after edge N+1.
REQ-026 Up mode on tick: seconds+1; 59 -> 0 with minutes+1; MIN_MAX:59 -> 00:00, keep RUNNING.
REQ-027 Down mode on tick: seconds-1; 0 -> 59 with minutes-1; 00:01 -> 00:00 transitions to EXPIRED with done pulsed the same edge.
REQ-028 EXPIRED holds 00:00, ignores start/stop/lap/load; exits only via reset or rst_n.
REQ-029 lap in RUNNING captures pre-tick count (value visible that cycle); lap_valid high the following cycle only; lap in other states ignored.
REQ-030 stop coincident with tick: tick discarded, count unchanged, prescaler held.

Reset
REQ-031 rst_n low asynchronously forces state IDLE, minutes=seconds=0, lap_min=lap_sec=0, lap_valid=0, done=0, status=00, prescaler=0, latched mode=0.
REQ-032 rst_n deassertion has no effect until the next rising clk edge.

Structure
REQ-033 Shared package lap_timer_pkg holds state encoding constants (IDLE/RUNNING/PAUSED/EXPIRED) and SEC_MAX=59.
REQ-034 One sub-module tick_prescaler (parameter TICK_DIV, inputs run/clear, output tick); remaining logic in lap_timer.

Verification
REQ-035 TICK_DIV=1, mode=0, start, run 61 cycles -> minutes=1, seconds=1, status=01.
REQ-036 TICK_DIV=4, start, stop after 9 cycles, wait 20, start, 4 more cycles -> seconds advances only while RUNNING, final seconds=3.
REQ-037 mode=1, load 0:03, start -> 0:02, 0:01, 0:00 on successive ticks; done one-cycle pulse; status=11; start ignored.
REQ-038 MIN_MAX=2, up from load 2:59 -> next tick 0:00, status 01.
REQ-039 lap at count 0:07 coincident with tick -> lap_sec=7, lap_valid high next cycle; seconds=8.
REQ-040 reset+stop+start same cycle while RUNNING -> status 00, count 00:00; rst_n pulse mid-count -> all outputs 0 immediately.
